// File: rtl/phase_meas_pkg.sv
// phase_meas_pkg: shared types, defaults and the round-robin channel picker
// for the phase_meas_sched block.
package phase_meas_pkg;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_A,
    COUNT,
    DONE
  } state_t;

  // First set bit of mask scanning upward from cur (incl=1) or cur+1 (incl=0),
  // wrapping at nch. Returns cur unchanged when no bit is set.
  function automatic logic [3:0] next_ch(input logic [15:0] mask, input logic [3:0] cur,
                                         input int nch, input logic incl);
    logic [3:0] res;
    logic [3:0] idx;
    logic       found;
    int         pos;
    res   = cur;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pos = (int'(cur) + k + (incl ? 0 : 1)) % nch;
      idx = pos[3:0];
      if (!found && (k < nch) && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_meas_sched_cnt.sv
// phase_cnt: rising-edge detectors for the muxed A/B inputs plus the
// saturating phase counter shared by all channels.
module phase_cnt
  import phase_meas_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic          run_i,
  input  logic          a_i,
  input  logic          b_i,
  output logic          a_rise_o,
  output logic          b_rise_o,
  output logic [CW-1:0] cnt_nxt_o
);

  logic          a_prev_q, b_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Previous-cycle levels; during load they take the newly selected channel's level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
    end else begin
      a_prev_q <= a_i;
      b_prev_q <= b_i;
    end
  end

  // Edges are masked while loading, since prev still holds the old channel then
  always_comb begin
    a_rise_o  = !load_i && a_i && !a_prev_q;
    b_rise_o  = !load_i && b_i && !b_prev_q;
    cnt_nxt_o = sat_inc(cnt_q);
    cnt_d     = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Phase counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_meas_sched.sv
// phase_meas_sched: round-robin phase-difference measurement over NCH encoder
// channel pairs using one shared edge detector/counter.
// Optional macro PHASE_SYNC_EN adds a 2-flop synchronizer on all encoder inputs.
module phase_meas_sched
  import phase_meas_pkg::*;
#(
  parameter int  NCH     = NCH_DEF,
  parameter int  CW      = CW_DEF,
  parameter int  TMO_CYC = 1000,
  parameter int  TW      = 16,
  localparam int CHW     = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [NCH-1:0] ch_mask,
  input  logic [NCH-1:0] enc_a,
  input  logic [NCH-1:0] enc_b,
  output logic [CW-1:0]  result,
  output logic [CHW-1:0] result_ch,
  output logic           result_vld,
  output logic           result_tmo,
  output logic           busy,
  output logic [CHW-1:0] cur_ch
);

  state_t         state_q, state_d;
  logic [CHW-1:0] cur_ch_q, cur_ch_d, ch_first, ch_after;
  logic [CW-1:0]  result_q, result_d;
  logic [CHW-1:0] result_ch_q, result_ch_d;
  logic           result_tmo_q, result_tmo_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [NCH-1:0] a_src, b_src;
  logic [15:0]    mask16;
  logic           a_m, b_m, a_rise, b_rise, tmo_hit;
  logic [CW-1:0]  cnt_nxt;

`ifdef PHASE_SYNC_EN
  logic [NCH-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;

  // Two-flop synchronizer; A and B see identical delay so phase is preserved
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_s1_q <= '0;
      a_s2_q <= '0;
      b_s1_q <= '0;
      b_s2_q <= '0;
    end else begin
      a_s1_q <= enc_a;
      a_s2_q <= a_s1_q;
      b_s1_q <= enc_b;
      b_s2_q <= b_s1_q;
    end
  end

  assign a_src = a_s2_q;
  assign b_src = b_s2_q;
`else
  assign a_src = enc_a;
  assign b_src = enc_b;
`endif

  assign a_m     = a_src[cur_ch_q];
  assign b_m     = b_src[cur_ch_q];
  assign tmo_hit = (tmo_q == TW'(TMO_CYC - 1));

  phase_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (state_q == SELECT),
    .clr_i    (state_q != COUNT),
    .run_i    (state_q == COUNT),
    .a_i      (a_m),
    .b_i      (b_m),
    .a_rise_o (a_rise),
    .b_rise_o (b_rise),
    .cnt_nxt_o(cnt_nxt)
  );

  // Round-robin candidates: inclusive search when starting, exclusive after a slot
  always_comb begin
    mask16             = '0;
    mask16[NCH-1:0]    = ch_mask;
    ch_first           = CHW'(next_ch(mask16, 4'(cur_ch_q), NCH, 1'b1));
    ch_after           = CHW'(next_ch(mask16, 4'(cur_ch_q), NCH, 1'b0));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an edge in the same cycle as the timeout wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (enable && |ch_mask) state_d = SELECT;
      SELECT: state_d = enable ? WAIT_A : IDLE;
      WAIT_A: begin
        if (!enable)      state_d = IDLE;
        else if (a_rise)  state_d = b_rise ? DONE : COUNT;
        else if (tmo_hit) state_d = DONE;
      end
      COUNT: begin
        if (!enable)                state_d = IDLE;
        else if (b_rise || tmo_hit) state_d = DONE;
      end
      DONE:    state_d = (enable && |ch_mask) ? SELECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state plus held result registers
  always_comb begin
    busy       = (state_q != IDLE);
    result_vld = (state_q == DONE);
    result     = result_q;
    result_ch  = result_ch_q;
    result_tmo = result_tmo_q;
    cur_ch     = cur_ch_q;
  end

  // Next values for channel pointer, timeout counter and the captured result
  always_comb begin
    tmo_d        = tmo_q;
    cur_ch_d     = cur_ch_q;
    result_d     = result_q;
    result_ch_d  = result_ch_q;
    result_tmo_d = result_tmo_q;
    case (state_q)
      IDLE:   if (state_d == SELECT) cur_ch_d = ch_first;
      SELECT: tmo_d = '0;
      WAIT_A, COUNT: begin
        tmo_d = tmo_q + 1'b1;
        if (state_d == DONE) begin
          result_ch_d = cur_ch_q;
          if (state_q == WAIT_A && a_rise) begin
            // A and B rose together
            result_d     = '0;
            result_tmo_d = 1'b0;
          end else if (state_q == COUNT && b_rise) begin
            result_d     = cnt_nxt;
            result_tmo_d = 1'b0;
          end else begin
            result_d     = '1;
            result_tmo_d = 1'b1;
          end
        end
      end
      // Pointer advances after every slot so a later restart resumes fairly
      DONE:    if (|ch_mask) cur_ch_d = ch_after;
      default: ;
    endcase
  end

  // Datapath/control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q        <= '0;
      cur_ch_q     <= '0;
      result_q     <= '0;
      result_ch_q  <= '0;
      result_tmo_q <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      cur_ch_q     <= cur_ch_d;
      result_q     <= result_d;
      result_ch_q  <= result_ch_d;
      result_tmo_q <= result_tmo_d;
    end
  end

endmodule

// File: tb/tb_phase_meas_sched.sv
// tb_phase_meas_sched: randomized self-checking bench for phase_meas_sched
// against a transaction-level model (expected channel order, phase, latency).
module tb_phase_meas_sched;

  localparam int TMO_CYC = 1000;
`ifdef PHASE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [3:0] ch_mask, enc_a, enc_b;
  logic [7:0] result;
  logic [1:0] result_ch, cur_ch;
  logic       result_vld, result_tmo, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vld_seen = 0;
  int exp_vld  = 0;
  int exp_ch   = 0;
  int last_ch  = 0;
  int slot_ch  = -1;

  phase_meas_sched #(.NCH(4), .CW(8), .TMO_CYC(TMO_CYC), .TW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ch_mask   (ch_mask),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .result    (result),
    .result_ch (result_ch),
    .result_vld(result_vld),
    .result_tmo(result_tmo),
    .busy      (busy),
    .cur_ch    (cur_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scheduling rule: first enabled channel scanning upward from cur (or cur+1), wrapping
  function automatic int rr_next(input logic [3:0] m, input int cur, input bit incl);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = (cur + k + (incl ? 0 : 1)) % 4;
      if (m[c]) return c;
    end
    return cur;
  endfunction

  // One clock; unscheduled, unmasked channels carry random noise on A/B
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (result_vld) vld_seen++;
    for (int i = 0; i < 4; i++) begin
      if (!ch_mask[i] && i != slot_ch) begin
        enc_a[i] = 1'($urandom_range(1, 0));
        enc_b[i] = 1'($urandom_range(1, 0));
      end
    end
  endtask

  // Newly enabled channels start quiet
  task automatic set_mask(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i] && !ch_mask[i]) begin
        enc_a[i] = 1'b0;
        enc_b[i] = 1'b0;
      end
    end
    ch_mask = m;
  endtask

  // Called at the cycle after which the DUT enters SELECT for exp_ch.
  task automatic run_slot(input int d_a, input int off, input bit pre, input bit pre_next,
                          input bit tmo_case, input bit chg, input logic [3:0] chg_mask);
    int ch, t0, t_b, w, exp_res;
    ch = exp_ch;
    slot_ch = ch;
    t0 = cyc;
    repeat (d_a) tick();
    chk("cur_ch", int'(cur_ch), ch);
    chk("busy", int'(busy), 1);
    if (pre) begin
      enc_a[ch] = 1'b0;
      repeat (3) tick();
    end
    t_b = cyc;
    if (!tmo_case) begin
      enc_a[ch] = 1'b1;
      if (pre_next) enc_a[rr_next(ch_mask, ch, 1'b0)] = 1'b1;
      if (chg) set_mask(chg_mask);
      repeat (off) tick();
      enc_b[ch] = 1'b1;
      t_b = cyc;
    end
    w = 0;
    while (!result_vld && w < TMO_CYC + 20) begin
      tick();
      w++;
    end
    if (!result_vld) begin
      chk("vld_timeout", int'(result_vld), 1);
    end else begin
      exp_res = tmo_case ? 255 : (off > 255 ? 255 : off);
      chk("result", int'(result), exp_res);
      chk("result_ch", int'(result_ch), ch);
      chk("result_tmo", int'(result_tmo), int'(tmo_case));
      // Timeout decided TMO_CYC cycles into WAIT_A/COUNT, DONE follows
      if (tmo_case) chk("tmo_lat", cyc - t0, TMO_CYC + 2);
      else          chk("vld_lat", cyc - t_b, LAT);
      exp_vld++;
    end
    enc_a[ch] = 1'b0;
    enc_b[ch] = 1'b0;
    last_ch = ch;
    if (ch_mask != 4'b0) exp_ch = rr_next(ch_mask, ch, 1'b0);
  endtask

  // Abort a slot in COUNT by dropping enable or asserting reset; then restart
  task automatic abort_slot(input bit use_rst);
    int ch, v0;
    ch = exp_ch;
    slot_ch = ch;
    repeat (3) tick();
    enc_a[ch] = 1'b1;
    repeat (4) tick();
    v0 = vld_seen;
    enable = 1'b0;
    if (use_rst) rst_n = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_vld", int'(result_vld), 0);
    if (use_rst) begin
      chk("rst_result", int'(result), 0);
      chk("rst_result_ch", int'(result_ch), 0);
      chk("rst_result_tmo", int'(result_tmo), 0);
      chk("rst_cur_ch", int'(cur_ch), 0);
      rst_n = 1'b1;
    end else begin
      chk("abort_cur_ch", int'(cur_ch), ch);
    end
    enc_a[ch] = 1'b0;
    repeat (5) tick();
    chk("abort_no_vld", vld_seen - v0, 0);
    exp_ch = rr_next(ch_mask, use_rst ? 0 : ch, 1'b1);
    enable = 1'b1;
  endtask

  initial begin
    int d, off;
    bit chg;
    logic [3:0] m;
    rst_n   = 1'b0;
    enable  = 1'b0;
    ch_mask = 4'b0;
    enc_a   = 4'b0;
    enc_b   = 4'b0;
    repeat (3) tick();
    chk("rst_state_busy", int'(busy), 0);
    chk("rst_vld", int'(result_vld), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_ch", int'(result_ch), 0);
    chk("rst_result_tmo", int'(result_tmo), 0);
    chk("rst_cur_ch", int'(cur_ch), 0);
    rst_n = 1'b1;
    tick();

    // Single channel, A->B 25 cycles
    set_mask(4'b0001);
    exp_ch = rr_next(ch_mask, 0, 1'b1);
    enable = 1'b1;
    run_slot(10, 25, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);

    // Alternate ch1/ch3; ch3's A is already high when it gets selected
    set_mask(4'b1010);
    exp_ch = rr_next(ch_mask, last_ch, 1'b0);
    run_slot(4, 5, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0);
    run_slot(4, 5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
    run_slot(3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    run_slot(3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);

    // Saturation, timeout, simultaneous edges
    run_slot(5, 300, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    run_slot(5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0);
    run_slot(6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);

    // Random slots with occasional mid-slot mask changes
    for (int n = 0; n < 30; n++) begin
      d   = $urandom_range(15, 2);
      off = ($urandom_range(9, 0) < 7) ? $urandom_range(40, 0) : $urandom_range(300, 0);
      chg = (off >= 4) && ($urandom_range(3, 0) == 0);
      m   = 4'($urandom_range(15, 1));
      run_slot(d, off, 1'b0, 1'b0, 1'b0, chg, m);
    end

    // Aborts during COUNT
    abort_slot(1'b0);
    run_slot(4, 7, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    abort_slot(1'b1);
    run_slot(4, 9, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);

    chk("vld_count", vld_seen, exp_vld);
    enable = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_meas_sched.md
Name: phase_meas_sched

Overview:
Round-robin scheduler that shares one phase-difference counter across NCH encoder channel pairs (enc_a[i], enc_b[i]).
- For each enabled channel in turn, it arms the counter, waits for an A rising edge, and counts clk cycles until the B rising edge.
- It reports the result tagged with the channel number, then moves on to the next channel.
- It sits between the encoder input pins and the readout/register logic that consumes per-channel phase values.

Parameters:
NCH, 4, number of encoder channel pairs (2..16)
CW, 8, width of phase count; saturates at 2^CW-1
TMO_CYC, 1000, cycles allowed in WAIT_A plus COUNT before a timeout aborts the slot
TW, 16, width of timeout counter (TMO_CYC < 2^TW)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  scheduler run enable
ch_mask  in  NCH  per-channel enable; bit i=1 means channel i is scheduled
enc_a  in  NCH  encoder A inputs
enc_b  in  NCH  encoder B inputs
result  out  CW  phase count of the last completed slot
result_ch  out  $clog2(NCH)  channel number of the result
result_vld  out  1  one-cycle pulse: result, result_ch and result_tmo are valid
result_tmo  out  1  slot ended by timeout; result = all ones
busy  out  1  high in every state except IDLE
cur_ch  out  $clog2(NCH)  channel currently selected

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE; result=0, result_ch=0, result_vld=0, result_tmo=0, busy=0, cur_ch=0; edge registers=0.
- Only the selected channel is sampled; enc_a[cur_ch] and enc_b[cur_ch] are muxed into a single edge detector and counter.
- Rising edge: prev=0, cur=1, using the previous-cycle register of the muxed signal.
- State machine, IDLE -> SELECT -> WAIT_A -> COUNT -> DONE -> SELECT...
- IDLE: leave when enable=1 and ch_mask!=0. First channel chosen is the lowest set bit at or above cur_ch.
- SELECT, 1 cycle:
  - load prev registers with the current values of the new channel, so the mux switch cannot create a false edge;
  - clear the counter and the timeout counter.
- WAIT_A:
  - on an A edge, go to COUNT with count=0;
  - if A and B edges occur in the same cycle, go to DONE with result 0.
- COUNT:
  - count increments every cycle, saturating at 2^CW-1;
  - on a B edge, go to DONE; result = cycles between the A-edge detection cycle and the B-edge detection cycle;
  - further A edges in COUNT are ignored; there is no restart.
- Timeout: counts cycles spent in WAIT_A+COUNT. When it reaches TMO_CYC, go to DONE with result_tmo=1 and result=all ones.
- DONE, 1 cycle:
  - result_vld=1; result, result_ch and result_tmo are registered and held until the next DONE.
  - Latency: result_vld rises 1 cycle after the B-edge detection cycle.
  - Next channel = next set bit of ch_mask after cur_ch, wrapping from NCH-1 to 0.
  - If that is the only set bit, the same channel repeats.
  - If ch_mask=0 or enable=0, go to IDLE; otherwise go to SELECT.
- enable=0 in SELECT, WAIT_A or COUNT: abort to IDLE next cycle; no result_vld. cur_ch keeps its value.
- Clearing the current channel's ch_mask bit mid-slot: the slot completes normally; the channel is skipped afterwards.
- Reset mid-slot: no result_vld; all outputs take their reset values.

Optional Feature:
PHASE_SYNC_EN
- Defined: all enc_a and enc_b bits pass through a 2-flop synchronizer before the mux. Both paths are delayed equally, so result values are unchanged. Edge-to-result_vld latency grows by 2 cycles. Synchronizer flops reset to 0.
- Undefined: inputs feed the mux directly, as already synchronous.

Decomposition:
- Package phase_meas_pkg holds:
  - state enum (IDLE, SELECT, WAIT_A, COUNT, DONE);
  - function next_ch(mask, cur) returning the round-robin next set bit;
  - CW/NCH default constants.
- Sub-module phase_cnt contains:
  - edge detectors for A and B, with a load input for SELECT;
  - saturating CW-bit counter;
  - outputs a_rise and b_rise.
- The FSM, timeout counter, mux and arbitration stay in the top module.

Test Plan:
- NCH=4, mask=4'b0001: A rises at cycle 10, B at cycle 35 -> result_vld with result=25, result_ch=0, result_tmo=0.
- mask=4'b1010, constant 5-cycle A->B offset on every channel -> results alternate ch1, ch3, ch1, ch3…, each with result=5; ch0/ch2 never reported.
- CW=8, B lags A by 300 cycles, TMO_CYC=1000 -> result=255, result_tmo=0. Same setup with B never rising -> result=255, result_tmo=1 exactly TMO_CYC cycles after SELECT.
- A and B rise in the same cycle -> result=0. A held high on the newly selected channel at SELECT -> no false edge; the measurement waits for the next A rise.
- enable dropped during COUNT, and rst_n=0 during COUNT -> no result_vld; busy=0 next cycle; all outputs at reset values after reset.
- With PHASE_SYNC_EN defined, repeat test 1 -> result=25; result_vld occurs 2 cycles later than without the macro.
